// File: rtl/host_if_bridge_pkg.sv
// Shared types and header field layout for the host ingress/egress bridge.
package host_if_bridge_pkg;

    localparam int unsigned MPU_W = 32;

    typedef logic [MPU_W-1:0] mpu_if_t;

    typedef enum logic [3:0] {
        OP_PROG = 4'd1,
        OP_DATA = 4'd2,
        OP_CTRL = 4'd3
    } host_op_t;

    // Header word layout: op in the top nibble, payload length in the low byte.
    localparam int unsigned HDR_OP_MSB = 31;
    localparam int unsigned HDR_OP_LSB = 28;
    localparam int unsigned HDR_LEN_W  = 8;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_PROG) || (op == OP_DATA) || (op == OP_CTRL);
    endfunction

endpackage

// File: rtl/host_if_bridge_if.sv
// Host command stream, engine request/response and status signals of the bridge.
interface host_if_bridge_if #(
    parameter int unsigned WIDTH_DATA = 32
);
    logic                        I_Host_Valid;
    logic [WIDTH_DATA-1:0]       I_Host_Data;
    logic                        O_Host_Ready;
    logic                        O_Req_IF;
    host_if_bridge_pkg::mpu_if_t O_Data_IF;
    logic                        I_Wait;
    logic                        I_Req_IF;
    host_if_bridge_pkg::mpu_if_t I_Data_IF;
    logic                        O_Rsp_Valid;
    logic [WIDTH_DATA-1:0]       O_Rsp_Data;
    logic                        I_Rsp_Ready;
    logic                        I_Clr;
    logic                        O_Err;
    logic                        O_Ovf;
    logic                        O_Busy;

    // Bridge side
    modport slave (
        input  I_Host_Valid, I_Host_Data, I_Wait, I_Req_IF, I_Data_IF, I_Rsp_Ready, I_Clr,
        output O_Host_Ready, O_Req_IF, O_Data_IF, O_Rsp_Valid, O_Rsp_Data, O_Err, O_Ovf, O_Busy
    );

    // Host / engine side
    modport master (
        output I_Host_Valid, I_Host_Data, I_Wait, I_Req_IF, I_Data_IF, I_Rsp_Ready, I_Clr,
        input  O_Host_Ready, O_Req_IF, O_Data_IF, O_Rsp_Valid, O_Rsp_Data, O_Err, O_Ovf, O_Busy
    );

endinterface

// File: rtl/host_if_bridge_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is accepted when a pop
// frees the slot in the same cycle.
module host_if_bridge_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointer update.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/host_if_bridge.sv
// Buffers whole host command packets and issues them to the engine, holding PROG packets
// until the engine waits for a program; buffers engine response words back to the host.
module host_if_bridge
    import host_if_bridge_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = 32,
    parameter int unsigned DEPTH_CMD  = 16,
    parameter int unsigned DEPTH_RSP  = 16
) (
    input  logic            clock,
    input  logic            reset,
    host_if_bridge_if.slave bus
);

    localparam int unsigned CMD_AW = $clog2(DEPTH_CMD);
    localparam int unsigned RSP_AW = $clog2(DEPTH_RSP);

    localparam logic [1:0] ING_HDR  = 2'd0;
    localparam logic [1:0] ING_PAY  = 2'd1;
    localparam logic [1:0] ING_DISC = 2'd2;

    localparam logic [1:0] EGR_IDLE  = 2'd0;
    localparam logic [1:0] EGR_CHECK = 2'd1;
    localparam logic [1:0] EGR_SEND  = 2'd2;

    localparam logic [CMD_AW:0] PKT_ONE = 1;

    logic [1:0]            r_ing, w_ing_nxt;
    logic [1:0]            r_egr, w_egr_nxt;
    logic [HDR_LEN_W-1:0]  r_rem, w_rem_nxt;
    logic [HDR_LEN_W-1:0]  r_cnt, w_cnt_nxt;
    logic                  r_first, w_first_nxt;
    logic [CMD_AW:0]       r_pkt_cnt;
    logic                  r_err, r_ovf;

    logic                  w_host_ready, w_host_xfer;
    logic [3:0]            w_in_op;
    logic [HDR_LEN_W-1:0]  w_in_len;
    logic                  w_in_legal;
    logic                  w_cmd_push, w_cmd_pop, w_pkt_last, w_err_set, w_hdr_pop;
    logic [WIDTH_DATA-1:0] w_cmd_head;
    logic                  w_cmd_full, w_cmd_empty;
    logic [CMD_AW:0]       w_cmd_count;
    logic [3:0]            w_head_op;
    logic [HDR_LEN_W-1:0]  w_head_len;
    logic [WIDTH_DATA-1:0] w_rsp_head;
    logic                  w_rsp_full, w_rsp_empty, w_rsp_pop, w_ovf_set;
    logic [RSP_AW:0]       w_rsp_count;

    assign w_host_ready = (r_ing == ING_DISC) | ~w_cmd_full;
    assign w_host_xfer  = bus.I_Host_Valid & w_host_ready;
    assign w_in_op      = bus.I_Host_Data[HDR_OP_MSB:HDR_OP_LSB];
    assign w_in_len     = bus.I_Host_Data[HDR_LEN_W-1:0];
    assign w_in_legal   = op_legal(w_in_op) && (32'(w_in_len) <= DEPTH_CMD - 1);
    assign w_head_op    = w_cmd_head[HDR_OP_MSB:HDR_OP_LSB];
    assign w_head_len   = w_cmd_head[HDR_LEN_W-1:0];

    host_if_bridge_fifo #(
        .WIDTH (WIDTH_DATA),
        .DEPTH (DEPTH_CMD)
    ) u_cmd_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_cmd_push),
        .i_data  (bus.I_Host_Data),
        .i_pop   (w_cmd_pop),
        .o_data  (w_cmd_head),
        .o_full  (w_cmd_full),
        .o_empty (w_cmd_empty),
        .o_count (w_cmd_count)
    );

    host_if_bridge_fifo #(
        .WIDTH (WIDTH_DATA),
        .DEPTH (DEPTH_RSP)
    ) u_rsp_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (bus.I_Req_IF),
        .i_data  (bus.I_Data_IF),
        .i_pop   (w_rsp_pop),
        .o_data  (w_rsp_head),
        .o_full  (w_rsp_full),
        .o_empty (w_rsp_empty),
        .o_count (w_rsp_count)
    );

    // Ingress parser: write legal packets, drop malformed ones word by word.
    always_comb begin
        w_ing_nxt  = r_ing;
        w_rem_nxt  = r_rem;
        w_cmd_push = 1'b0;
        w_pkt_last = 1'b0;
        w_err_set  = 1'b0;
        case (r_ing)
            ING_HDR: begin
                if (w_host_xfer) begin
                    if (w_in_legal) begin
                        w_cmd_push = 1'b1;
                        if (w_in_len == '0) begin
                            w_pkt_last = 1'b1;
                        end else begin
                            w_rem_nxt = w_in_len;
                            w_ing_nxt = ING_PAY;
                        end
                    end else begin
                        w_err_set = 1'b1;
                        if (w_in_len != '0) begin
                            w_rem_nxt = w_in_len;
                            w_ing_nxt = ING_DISC;
                        end
                    end
                end
            end
            ING_PAY, ING_DISC: begin
                if (w_host_xfer) begin
                    w_cmd_push = (r_ing == ING_PAY);
                    if (r_rem == 8'd1) begin
                        w_pkt_last = (r_ing == ING_PAY);
                        w_ing_nxt  = ING_HDR;
                    end else begin
                        w_rem_nxt = r_rem - 8'd1;
                    end
                end
            end
            default: w_ing_nxt = ING_HDR;
        endcase
    end

    // Egress: wait for a complete packet, gate PROG on I_Wait, then stream it out.
    always_comb begin
        w_egr_nxt   = r_egr;
        w_cnt_nxt   = r_cnt;
        w_first_nxt = r_first;
        w_cmd_pop   = 1'b0;
        case (r_egr)
            EGR_IDLE: begin
                if (r_pkt_cnt != '0) w_egr_nxt = EGR_CHECK;
            end
            EGR_CHECK: begin
                if (!((w_head_op == OP_PROG) && !bus.I_Wait)) begin
                    w_cnt_nxt   = w_head_len;
                    w_first_nxt = 1'b1;
                    w_egr_nxt   = EGR_SEND;
                end
            end
            EGR_SEND: begin
                w_cmd_pop   = 1'b1;
                w_first_nxt = 1'b0;
                if (r_cnt == '0) begin
                    w_egr_nxt = (r_pkt_cnt > PKT_ONE) ? EGR_CHECK : EGR_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: w_egr_nxt = EGR_IDLE;
        endcase
    end

    assign w_hdr_pop = (r_egr == EGR_SEND) & r_first;
    assign w_rsp_pop = bus.I_Rsp_Ready & ~w_rsp_empty;
    assign w_ovf_set = bus.I_Req_IF & w_rsp_full & ~w_rsp_pop;

    // FSM and packet-count state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ing     <= ING_HDR;
            r_rem     <= '0;
            r_egr     <= EGR_IDLE;
            r_cnt     <= '0;
            r_first   <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            r_ing   <= w_ing_nxt;
            r_rem   <= w_rem_nxt;
            r_egr   <= w_egr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_first <= w_first_nxt;
            if (w_pkt_last && !w_hdr_pop) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end else if (!w_pkt_last && w_hdr_pop) begin
                r_pkt_cnt <= r_pkt_cnt - 1'b1;
            end
        end
    end

    // Sticky error flags; a new event wins over a same-cycle clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_err <= w_err_set | (r_err & ~bus.I_Clr);
            r_ovf <= w_ovf_set | (r_ovf & ~bus.I_Clr);
        end
    end

    assign bus.O_Host_Ready = w_host_ready;
    assign bus.O_Req_IF     = (r_egr == EGR_SEND);
    assign bus.O_Data_IF    = (r_egr == EGR_SEND) ? w_cmd_head : '0;
    assign bus.O_Rsp_Valid  = ~w_rsp_empty;
    assign bus.O_Rsp_Data   = w_rsp_empty ? '0 : w_rsp_head;
    assign bus.O_Err        = r_err;
    assign bus.O_Ovf        = r_ovf;
    assign bus.O_Busy       = (r_pkt_cnt != '0) | (r_egr != EGR_IDLE) | (r_ing != ING_HDR);

    // Occupancy can never exceed the storage depth.
    a_cmd_count: assert property (@(posedge clock) disable iff (reset)
        32'(w_cmd_count) <= DEPTH_CMD);
    a_rsp_count: assert property (@(posedge clock) disable iff (reset)
        32'(w_rsp_count) <= DEPTH_RSP);
    a_send_nonempty: assert property (@(posedge clock) disable iff (reset)
        (r_egr == EGR_SEND) |-> !w_cmd_empty);

endmodule

// File: tb/tb_host_if_bridge.sv
// Scoreboard bench for host_if_bridge: expected engine and host words are queued as
// stimulus is driven and compared as the bridge emits them.
module tb_host_if_bridge;
    import host_if_bridge_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    host_if_bridge_if #(.WIDTH_DATA(32)) bus ();

    host_if_bridge dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int req_cnt  = 0;
    int first_req_cyc = -1;
    int rsp_pop_cnt   = 0;
    int stalls   = 0;
    int xfer_cyc = 0;

    logic [31:0] eq [$];
    logic [31:0] rq [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitors, sampled mid-cycle.
    always @(negedge clock) begin
        logic [31:0] e;
        if (!reset) begin
            if (bus.O_Req_IF) begin
                if (first_req_cyc < 0) first_req_cyc = cyc;
                req_cnt++;
                if (eq.size() == 0) begin
                    check("req_unexpected", 32'(bus.O_Req_IF), 32'd0);
                end else begin
                    e = eq.pop_front();
                    check("req_data", bus.O_Data_IF, e);
                end
            end
            if (bus.O_Rsp_Valid && bus.I_Rsp_Ready) begin
                rsp_pop_cnt++;
                if (rq.size() == 0) begin
                    check("rsp_unexpected", 32'(bus.O_Rsp_Valid), 32'd0);
                end else begin
                    e = rq.pop_front();
                    check("rsp_data", bus.O_Rsp_Data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk_hdr(input logic [3:0] op, input logic [7:0] len);
        return {op, 20'h0, len};
    endfunction

    task automatic host_word(input logic [31:0] d);
        int n = 0;
        bus.I_Host_Valid = 1'b1;
        bus.I_Host_Data  = d;
        @(negedge clock);
        while (!bus.O_Host_Ready && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (n >= 200) check("host_ready_timeout", 32'(n), 32'd0);
        stalls  += n;
        xfer_cyc = cyc;
        @(posedge clock);
        #1;
        bus.I_Host_Valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] op, input int len, input bit expect_out);
        logic [31:0] w;
        w = mk_hdr(op, 8'(len));
        if (expect_out) eq.push_back(w);
        host_word(w);
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            if (expect_out) eq.push_back(w);
            host_word(w);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((eq.size() != 0 || bus.O_Busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic wait_rsp_drain(input int budget);
        int n = 0;
        while (rq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("rsp_drain_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic pulse_clr();
        bus.I_Clr = 1'b1;
        tick();
        bus.I_Clr = 1'b0;
    endtask

    initial begin
        int t_last;
        int wait_cyc;
        bus.I_Host_Valid = 1'b0;
        bus.I_Host_Data  = '0;
        bus.I_Wait       = 1'b0;
        bus.I_Req_IF     = 1'b0;
        bus.I_Data_IF    = '0;
        bus.I_Rsp_Ready  = 1'b0;
        bus.I_Clr        = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_host_ready", 32'(bus.O_Host_Ready), 32'd1);
        check("rst_req", 32'(bus.O_Req_IF), 32'd0);
        check("rst_data", bus.O_Data_IF, 32'd0);
        check("rst_rsp_valid", 32'(bus.O_Rsp_Valid), 32'd0);
        check("rst_rsp_data", bus.O_Rsp_Data, 32'd0);
        check("rst_err", 32'(bus.O_Err), 32'd0);
        check("rst_ovf", 32'(bus.O_Ovf), 32'd0);
        check("rst_busy", 32'(bus.O_Busy), 32'd0);
        tick();

        // DATA len=3: four words, header first, third cycle after last input
        first_req_cyc = -1; req_cnt = 0;
        send_pkt(OP_DATA, 3, 1'b1);
        t_last = xfer_cyc;
        wait_idle(100);
        check("data_latency", 32'(first_req_cyc - t_last), 32'd3);
        check("data_count", 32'(req_cnt), 32'd4);

        // PROG held while I_Wait=0; DATA behind it is blocked too
        first_req_cyc = -1; req_cnt = 0;
        send_pkt(OP_PROG, 1, 1'b1);
        send_pkt(OP_DATA, 0, 1'b1);
        repeat (10) tick();
        check("prog_blocked", 32'(req_cnt), 32'd0);
        check("prog_busy", 32'(bus.O_Busy), 32'd1);
        bus.I_Wait = 1'b1;
        wait_cyc = cyc;
        wait_idle(100);
        bus.I_Wait = 1'b0;
        check("prog_release", 32'(first_req_cyc - wait_cyc), 32'd1);
        check("prog_count", 32'(req_cnt), 32'd3);

        // Illegal op dropped, following DATA len=0 passes
        first_req_cyc = -1; req_cnt = 0; stalls = 0;
        send_pkt(4'hF, 2, 1'b0);
        send_pkt(OP_DATA, 0, 1'b1);
        wait_idle(100);
        check("badop_err", 32'(bus.O_Err), 32'd1);
        check("badop_stalls", 32'(stalls), 32'd0);
        check("badop_count", 32'(req_cnt), 32'd1);
        pulse_clr();
        check("badop_clr", 32'(bus.O_Err), 32'd0);

        // Oversize packet (len=16) dropped with its payload
        first_req_cyc = -1; req_cnt = 0; stalls = 0;
        send_pkt(OP_DATA, 16, 1'b0);
        repeat (5) tick();
        check("big_err", 32'(bus.O_Err), 32'd1);
        check("big_stalls", 32'(stalls), 32'd0);
        check("big_count", 32'(req_cnt), 32'd0);
        check("big_busy", 32'(bus.O_Busy), 32'd0);
        pulse_clr();
        check("big_clr", 32'(bus.O_Err), 32'd0);

        // Response overflow: 17 words with no host pops
        rsp_pop_cnt = 0;
        bus.I_Rsp_Ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.I_Req_IF  = 1'b1;
            bus.I_Data_IF = 32'hA000_0000 + 32'(i);
            if (i < 16) rq.push_back(32'hA000_0000 + 32'(i));
            tick();
        end
        bus.I_Req_IF = 1'b0;
        @(negedge clock);
        check("ovf_set", 32'(bus.O_Ovf), 32'd1);
        check("ovf_valid", 32'(bus.O_Rsp_Valid), 32'd1);
        tick();
        bus.I_Rsp_Ready = 1'b1;
        wait_rsp_drain(100);
        check("ovf_pops", 32'(rsp_pop_cnt), 32'd16);
        check("ovf_empty", 32'(bus.O_Rsp_Valid), 32'd0);
        bus.I_Rsp_Ready = 1'b0;
        pulse_clr();
        check("ovf_clr", 32'(bus.O_Ovf), 32'd0);

        // Same stimulus, host pops on the 17th cycle: no overflow
        rsp_pop_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) bus.I_Rsp_Ready = 1'b1;
            bus.I_Req_IF  = 1'b1;
            bus.I_Data_IF = 32'hB000_0000 + 32'(i);
            rq.push_back(32'hB000_0000 + 32'(i));
            tick();
        end
        bus.I_Req_IF = 1'b0;
        @(negedge clock);
        check("nopvf_flag", 32'(bus.O_Ovf), 32'd0);
        tick();
        wait_rsp_drain(100);
        check("noovf_pops", 32'(rsp_pop_cnt), 32'd17);
        bus.I_Rsp_Ready = 1'b0;

        // Reset in the middle of a packet discards it
        first_req_cyc = -1; req_cnt = 0;
        host_word(mk_hdr(OP_DATA, 8'd4));
        host_word($urandom);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clock);
        check("midrst_busy", 32'(bus.O_Busy), 32'd0);
        check("midrst_ready", 32'(bus.O_Host_Ready), 32'd1);
        repeat (10) tick();
        check("midrst_noreq", 32'(req_cnt), 32'd0);
        send_pkt(OP_DATA, 0, 1'b1);
        wait_idle(100);
        check("midrst_after", 32'(req_cnt), 32'd1);

        check("eq_left", 32'(eq.size()), 32'd0);
        check("rq_left", 32'(rq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
